transmitter: RTL and testbench

Transmit-side counterpart of the shutter-glasses receiver. It takes the display's frame sync (`vsync`) and eye indicator and emits one positive RF-keying pulse on `signal` at the start of every right-eye frame. The receiver resets its shutter timer on the rising edge of that pulse and splits each period into its right and left halves. The block also measures the stereo-pair period in 1 kHz ticks, reports lock, and stops keying when sync is lost.

---
 rtl/tx_pkg.sv | 14 +
 rtl/tick_gen.sv | 32 +++
 rtl/transmitter.sv | 215 +++++++++++++++++++++
 tb/tb_transmitter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the shutter-glasses transmitter.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        TRACK,
        HOLD
    } tx_state_t;

    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module tick_gen #(
    parameter int CLK_DIV = 30000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Wrap the divider at CLK_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/transmitter.sv
// Transmitter: emits one RF keying pulse at the start of every right-eye
// frame, measures the stereo-pair period in ticks and reports lock.
// Define TX_HOLDOVER_EN to keep synthesizing pulses for a while after sync loss.
module transmitter
    import tx_pkg::*;
#(
    parameter int CLK_DIV       = 30000,
    parameter int PULSE_TICKS   = 2,
    parameter int TIMEOUT_TICKS = 200,
    parameter int HOLDOVER_MAX  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             eye_left,
    output logic             signal,
    output logic             locked,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_TICKS);
    localparam logic [3:0]       PW_LAST     = 4'(PULSE_TICKS - 1);

    if (PULSE_TICKS < 1 || PULSE_TICKS > 15) begin : g_chk_pulse
        $error("transmitter: PULSE_TICKS must be 1..15");
    end
    if (TIMEOUT_TICKS < 2 || TIMEOUT_TICKS > 255) begin : g_chk_timeout
        $error("transmitter: TIMEOUT_TICKS must be 2..255");
    end
    if (HOLDOVER_MAX < 1) begin : g_chk_holdover
        $error("transmitter: HOLDOVER_MAX must be at least 1");
    end

`ifdef TX_HOLDOVER_EN
    localparam int            HO_W   = ($clog2(HOLDOVER_MAX + 1) > 3) ? $clog2(HOLDOVER_MAX + 1) : 3;
    localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOVER_MAX);

    logic [HO_W-1:0] ho_q;
    logic [HO_W-1:0] ho_d;
`endif

    logic             tick;
    logic             vs_s1_q, vs_s2_q, vs_s3_q;
    logic             eye_s1_q, eye_s2_q;
    logic             qev_q;
    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             locked_q, locked_d;
    logic             signal_q, signal_d;
    logic [3:0]       pw_q, pw_d;
    logic             start;
    logic             abort;
    logic             hold_clr;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizers, then the edge register that yields qev_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            vs_s3_q  <= 1'b0;
            eye_s1_q <= 1'b0;
            eye_s2_q <= 1'b0;
            qev_q    <= 1'b0;
        end else begin
            vs_s1_q  <= vsync;
            vs_s2_q  <= vs_s1_q;
            vs_s3_q  <= vs_s2_q;
            eye_s1_q <= eye_left;
            eye_s2_q <= eye_s1_q;
            qev_q    <= vs_s2_q & ~vs_s3_q & ~eye_s2_q;
        end
    end

    // Next state, lock/period update and pulse start/abort requests.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        locked_d = locked_q;
        start    = 1'b0;
        abort    = 1'b0;
        hold_clr = 1'b0;
`ifdef TX_HOLDOVER_EN
        ho_d     = ho_q;
`endif
        case (state_q)
            IDLE: begin
                if (qev_q) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (qev_q) begin
                    state_d  = TRACK;
                    period_d = cnt_q;
                    locked_d = 1'b1;
                    start    = 1'b1;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            TRACK: begin
                if (qev_q) begin
                    period_d = cnt_q;
                    start    = 1'b1;
                end else if (cnt_q == TIMEOUT_VAL) begin
`ifdef TX_HOLDOVER_EN
                    // cnt restarts so the first synthesized pulse lands one period later.
                    state_d  = HOLD;
                    hold_clr = 1'b1;
                    ho_d     = '0;
`else
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    abort    = 1'b1;
`endif
                end
            end
`ifdef TX_HOLDOVER_EN
            HOLD: begin
                if (qev_q) begin
                    state_d = TRACK;
                    ho_d    = '0;
                    start   = 1'b1;
                end else if (period_q == '0) begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    abort    = 1'b1;
                end else if (cnt_q == period_q) begin
                    hold_clr = 1'b1;
                    if (ho_q == HO_MAX) begin
                        state_d  = IDLE;
                        locked_d = 1'b0;
                        abort    = 1'b1;
                    end else begin
                        ho_d  = ho_q + HO_W'(1);
                        start = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tick counter and pulse width logic; qev beats a coincident tick.
    always_comb begin
        cnt_d    = cnt_q;
        signal_d = signal_q;
        pw_d     = pw_q;
        if (qev_q || hold_clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (abort) begin
            signal_d = 1'b0;
        end else if (start) begin
            signal_d = 1'b1;
            pw_d     = '0;
        end else if (signal_q && tick) begin
            if (pw_q == PW_LAST) begin
                signal_d = 1'b0;
            end else begin
                pw_d = pw_q + 4'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            locked_q <= 1'b0;
            signal_q <= 1'b0;
            pw_q     <= '0;
`ifdef TX_HOLDOVER_EN
            ho_q     <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            locked_q <= locked_d;
            signal_q <= signal_d;
            pw_q     <= pw_d;
`ifdef TX_HOLDOVER_EN
            ho_q     <= ho_d;
`endif
        end
    end

    assign signal = signal_q;
    assign locked = locked_q;
    assign period = period_q;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter (CLK_DIV=4, PULSE_TICKS=2, TIMEOUT_TICKS=20, HOLDOVER_MAX=2).
module tb_transmitter;

    localparam int CLK_DIV       = 4;
    localparam int PULSE_TICKS   = 2;
    localparam int TIMEOUT_TICKS = 20;
    localparam int HOLDOVER_MAX  = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       vsync    = 1'b0;
    logic       eye_left = 1'b0;
    logic       signal;
    logic       locked;
    logic [7:0] period;

    int errors = 0;
    int checks = 0;

    // Reference model state: edge index since reset, last counter clear edge,
    // mode (0 idle, 1 armed, 2 tracking, 3 holding), pulse end edge.
    int m_k, m_clr, m_mode, m_per, m_lck, m_end;
`ifdef TX_HOLDOVER_EN
    int m_ho;
`endif
    bit m_sig;
    bit vh[$];
    bit eh[$];

    int rises    = 0;
    bit sig_prev = 1'b0;

    transmitter #(
        .CLK_DIV       (CLK_DIV),
        .PULSE_TICKS   (PULSE_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .HOLDOVER_MAX  (HOLDOVER_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (vsync),
        .eye_left (eye_left),
        .signal   (signal),
        .locked   (locked),
        .period   (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // First tick edge strictly after edge s.
    function automatic int tick_after(input int s);
        return s + 1 + (CLK_DIV - 1 - ((s + 1) % CLK_DIV));
    endfunction

    task automatic model_edge();
        bit qev, start, abort, hclr;
        int cnt;
        if (!rst_n) begin
            m_k = 0; m_clr = -1; m_mode = 0; m_per = 0; m_lck = 0; m_end = -1; m_sig = 1'b0;
`ifdef TX_HOLDOVER_EN
            m_ho = 0;
`endif
            vh.delete();
            eh.delete();
            return;
        end
        vh.push_back(vsync);
        eh.push_back(eye_left);
        // Raw sample three edges back must be a right-eye rise.
        qev = (m_k >= 3) && vh[m_k-3] && !eh[m_k-3] && ((m_k < 4) || !vh[m_k-4]);
        // Ticks strictly between the last clear and this edge, saturated.
        cnt = m_k / CLK_DIV - (m_clr + 1) / CLK_DIV;
        if (cnt > 255) cnt = 255;
        start = 0; abort = 0; hclr = 0;
        case (m_mode)
            0: if (qev) m_mode = 1;
            1: begin
                if (qev) begin
                    m_mode = 2; m_per = cnt; m_lck = 1; start = 1;
                end else if (cnt == TIMEOUT_TICKS) begin
                    m_mode = 0; abort = 1;
                end
            end
            2: begin
                if (qev) begin
                    m_per = cnt; start = 1;
                end else if (cnt == TIMEOUT_TICKS) begin
`ifdef TX_HOLDOVER_EN
                    m_mode = 3; m_ho = 0; hclr = 1;
`else
                    m_mode = 0; m_lck = 0; abort = 1;
`endif
                end
            end
            default: begin
`ifdef TX_HOLDOVER_EN
                if (qev) begin
                    m_mode = 2; m_ho = 0; start = 1;
                end else if (m_per == 0) begin
                    m_mode = 0; m_lck = 0; abort = 1;
                end else if (cnt == m_per) begin
                    hclr = 1;
                    if (m_ho == HOLDOVER_MAX) begin
                        m_mode = 0; m_lck = 0; abort = 1;
                    end else begin
                        m_ho++; start = 1;
                    end
                end
`endif
            end
        endcase
        if (qev || hclr) m_clr = m_k;
        if (abort) m_end = m_k;
        else if (start) m_end = tick_after(m_k) + (PULSE_TICKS - 1) * CLK_DIV;
        m_sig = (m_k < m_end);
        m_k++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("signal", signal, m_sig);
        check("locked", locked, m_lck);
        check("period", period, m_per);
        if (signal === 1'b1 && !sig_prev) rises++;
        sig_prev = (signal === 1'b1);
    endtask

    task automatic frame(input bit left, input int hi, input int len);
        vsync    = 1'b1;
        eye_left = left;
        for (int i = 0; i < len; i++) begin
            if (i == hi) vsync = 1'b0;
            step();
        end
        vsync = 1'b0;
    endtask

    initial begin
        int w;
        int n;

        // Reset
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_signal", signal, 0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        rst_n = 1'b1;

        // 1: idle
        rises = 0;
        repeat (201) step();
        check("t1_rises", rises, 0);
        check("t1_locked", locked, 0);

        // 2: two right-eye rises 40 cycles apart
        frame(1'b0, 8, 40);
        check("t2_first_no_pulse", rises, 0);
        vsync = 1'b1; eye_left = 1'b0; w = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 8) vsync = 1'b0;
            step();
            if (i == 2) check("t2_lat3_low", signal, 0);
            if (i == 3) begin
                check("t2_lat4_high", signal, 1);
                check("t2_locked", locked, 1);
                check("t2_period10", period, 10);
            end
            if (signal === 1'b1) w++;
        end
        check("t2_width_5_8", (w >= 5 && w <= 8), 1);

        // 3: alternating left/right frames with jittered gaps
        rises = 0;
        for (int f = 0; f < 6; f++) begin
            frame(1'b1, 4, 20 + $urandom_range(0, 2));
            frame(1'b0, 4, 20 + $urandom_range(0, 2));
        end
        check("t3_rises", rises, 6);
        check("t3_locked", locked, 1);
        check("t3_period_range", (period >= 9 && period <= 11), 1);

        // 4: retrigger while the pulse is high
        vsync = 1'b1; eye_left = 1'b0;
        step();
        vsync = 1'b0;
        n = 0;
        while (signal !== 1'b1 && n < 10) begin step(); n++; end
        check("t4_first_start", signal, 1);
        w = 1;
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        if (signal === 1'b1) w++;
        n = 0;
        while (signal === 1'b1 && n < 30) begin
            step(); n++;
            if (signal === 1'b1) w++;
        end
        check("t4_retrig_width_9_12", (w >= 9 && w <= 12), 1);
        repeat (30) step();

        // Random frames, including gaps long enough to time out
        for (int f = 0; f < 16; f++) begin
            frame(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(6, 90));
        end

        // 5: sync stops after lock
        frame(1'b0, 4, 40);
        frame(1'b0, 4, 40);
        check("t5_locked_before", locked, 1);
        rises = 0;
        vsync = 1'b1; eye_left = 1'b0;
        step();
        vsync = 1'b0;
        n = 1;
        while (locked === 1'b1 && n < 600) begin step(); n++; end
        check("t5_unlocked", locked, 0);
        check("t5_signal_low", signal, 0);
`ifdef TX_HOLDOVER_EN
        check("t5_rises", rises, 1 + HOLDOVER_MAX);
`else
        check("t5_rises", rises, 1);
        check("t5_unlock_time", (n >= 80 && n <= 88), 1);
`endif
        repeat (10) step();

        // 6: reset mid-pulse, then relock needs two syncs
        frame(1'b0, 4, 40);
        frame(1'b0, 4, 40);
        vsync = 1'b1; eye_left = 1'b0;
        step();
        vsync = 1'b0;
        n = 0;
        while (signal !== 1'b1 && n < 10) begin step(); n++; end
        check("t6_pulse_high", signal, 1);
        rst_n = 1'b0;
        step();
        check("t6_rst_signal", signal, 0);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_period", period, 0);
        rst_n = 1'b1;
        rises = 0;
        frame(1'b0, 4, 40);
        check("t6_first_no_pulse", rises, 0);
        check("t6_first_unlocked", locked, 0);
        vsync = 1'b1; eye_left = 1'b0;
        step();
        vsync = 1'b0;
        repeat (3) step();
        check("t6_relock_signal", signal, 1);
        check("t6_relock_locked", locked, 1);
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
